muldiv_ctrl: RTL and testbench

Sequencer for the HI/LO-producing arithmetic of the MIPS core (MULT, MULTU, DIV, DIVU). It sits beside the EX-stage ALU and owns the iterative restoring divider and, optionally, an iterative shift-add multiplier. It raises a stall request to the hazard unit while an operation is in flight. It presents a one-cycle `done` pulse with HI/LO results for the HI/LO register write.

---
 rtl/muldiv_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_muldiv_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_ctrl.sv
// HI/LO sequencer for MULT/MULTU/DIV/DIVU: 32-step restoring divider plus a multiplier.
// Define MULDIV_ITER_MUL_EN for a 32-step shift-add multiplier; otherwise the multiply is single-cycle combinational.
module muldiv_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

`ifdef MULDIV_ITER_MUL_EN
  localparam logic ITER_MUL = 1'b1;
`else
  localparam logic ITER_MUL = 1'b0;
`endif

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] opb_q, opb_d;
  logic        is_div_q, is_div_d;
  logic        q_neg_q, q_neg_d;
  logic        r_neg_q, r_neg_d;
  logic        done_q, done_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        op_signed, op_div, multi_cycle, start_ok;
  logic [31:0] a_mag, b_mag;
  logic [32:0] rem_shift, diff;
  logic        div_ge;
  logic [31:0] div_rem, div_quo, div_lo, div_hi;

  assign op_signed   = ~op[0];
  assign op_div      = op[1];
  assign a_mag       = (op_signed && a[31]) ? (32'd0 - a) : a;
  assign b_mag       = (op_signed && b[31]) ? (32'd0 - b) : b;
  assign multi_cycle = op_div ? (b != 32'd0) : ITER_MUL;
  assign start_ok    = start && !flush && (state_q != RUN);

  // One restoring step: shift {rem, quo} left, trial-subtract, keep if non-negative.
  assign rem_shift = {rem_q, quo_q[31]};
  assign diff      = rem_shift - {1'b0, opb_q};
  assign div_ge    = ~diff[32];
  assign div_rem   = div_ge ? diff[31:0] : rem_shift[31:0];
  assign div_quo   = {quo_q[30:0], div_ge};
  assign div_lo    = q_neg_q ? (32'd0 - div_quo) : div_quo;
  assign div_hi    = r_neg_q ? (32'd0 - div_rem) : div_rem;

`ifdef MULDIV_ITER_MUL_EN
  logic [32:0] mul_sum;
  logic [31:0] mul_rem, mul_quo;
  logic [63:0] mul_prod, mul_res;

  // Shift-add: upper half accumulates the multiplicand, product shifts right into quo.
  assign mul_sum  = {1'b0, rem_q} + (quo_q[0] ? {1'b0, opb_q} : 33'd0);
  assign mul_rem  = mul_sum[32:1];
  assign mul_quo  = {mul_sum[0], quo_q[31:1]};
  assign mul_prod = {mul_rem, mul_quo};
  assign mul_res  = q_neg_q ? (64'd0 - mul_prod) : mul_prod;
`else
  logic [63:0] a_ext, b_ext, prod;

  assign a_ext = op_signed ? {{32{a[31]}}, a} : {32'd0, a};
  assign b_ext = op_signed ? {{32{b[31]}}, b} : {32'd0, b};
  assign prod  = a_ext * b_ext;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    opb_d    = opb_q;
    is_div_d = is_div_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;
    done_d   = 1'b0;
    hi_d     = hi_q;
    lo_d     = lo_q;

    case (state_q)
      RUN: begin
        rem_d = div_rem;
        quo_d = div_quo;
`ifdef MULDIV_ITER_MUL_EN
        if (!is_div_q) begin
          rem_d = mul_rem;
          quo_d = mul_quo;
        end
`endif
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = DONE;
          done_d  = 1'b1;
          hi_d    = div_hi;
          lo_d    = div_lo;
`ifdef MULDIV_ITER_MUL_EN
          if (!is_div_q) begin
            hi_d = mul_res[63:32];
            lo_d = mul_res[31:0];
          end
`endif
        end
      end
      default: begin
        state_d = IDLE;
        if (start_ok) begin
          cnt_d    = 5'd0;
          is_div_d = op_div;
          q_neg_d  = op_signed && (a[31] ^ b[31]);
          r_neg_d  = op_signed && a[31];
          rem_d    = 32'd0;
          if (op_div) begin
            quo_d = a_mag;
            opb_d = b_mag;
            if (b == 32'd0) begin
              state_d = DONE;
              done_d  = 1'b1;
              hi_d    = a;
              lo_d    = '1;
            end else begin
              state_d = RUN;
            end
          end else begin
`ifdef MULDIV_ITER_MUL_EN
            quo_d   = b_mag;
            opb_d   = a_mag;
            state_d = RUN;
`else
            state_d = DONE;
            done_d  = 1'b1;
            hi_d    = prod[63:32];
            lo_d    = prod[31:0];
`endif
          end
        end
      end
    endcase

    // Flush aborts everything but leaves the architectural HI/LO untouched.
    if (flush) begin
      state_d = IDLE;
      done_d  = 1'b0;
      cnt_d   = 5'd0;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 5'd0;
      rem_q    <= 32'd0;
      quo_q    <= 32'd0;
      opb_q    <= 32'd0;
      is_div_q <= 1'b0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      opb_q    <= opb_d;
      is_div_q <= is_div_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
      done_q   <= done_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign busy = !rst && ((((state_q == IDLE) || (state_q == DONE)) && start && !flush && multi_cycle)
                         || ((state_q == RUN) && !flush));
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed cases plus random ops against an arithmetic reference model.
// Honours MULDIV_ITER_MUL_EN for the expected multiply latency.
module tb_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;
  logic [31:0] lastHi, lastLo;

  always #5 clk = ~clk;

  muldiv_ctrl dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .op   (op),
    .a    (a),
    .b    (b),
    .flush(flush),
    .busy (busy),
    .done (done),
    .hi   (hi),
    .lo   (lo)
  );

  // Reference result {hi, lo} from plain 64-bit arithmetic.
  function automatic logic [63:0] refModel(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, q, r;
    logic [63:0] res;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      2'd0: res = sx * sy;
      2'd1: res = {32'd0, x} * {32'd0, y};
      2'd2: begin
        if (y == 32'd0) res = {x, 32'hFFFFFFFF};
        else begin
          q = sx / sy;
          r = sx % sy;
          res = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (y == 32'd0) res = {x, 32'hFFFFFFFF};
        else res = {x % y, x / y};
      end
    endcase
    return res;
  endfunction

  function automatic int expLatency(input logic [1:0] o, input logic [31:0] y);
    if (o[1]) return (y == 32'd0) ? 1 : 33;
`ifdef MULDIV_ITER_MUL_EN
    return 33;
`else
    return 1;
`endif
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic randomNoise();
    op = 2'($urandom);
    a  = $urandom;
    b  = $urandom;
  endtask

  // Issues one op at cycle 0, then watches 40 cycles for busy/done behaviour and the result.
  task automatic applyStimulus(input string tag, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] expv;
    int lat, busyCount, doneCount, doneAt;
    logic [31:0] gotHi, gotLo;
    expv = refModel(o, x, y);
    lat = expLatency(o, y);
    busyCount = 0;
    doneCount = 0;
    doneAt = -1;
    gotHi = 32'hDEADBEEF;
    gotLo = 32'hDEADBEEF;
    for (int k = 0; k <= 40; k++) begin
      @(posedge clk); #1;
      if (k == 0) begin
        start = 1'b1; op = o; a = x; b = y;
      end else begin
        start = 1'b0; randomNoise();
      end
      #1;
      if (busy) busyCount++;
      if (done) begin
        doneCount++;
        doneAt = k;
        gotHi = hi;
        gotLo = lo;
      end
    end
    checkOutput({tag, " doneAt"}, 64'(doneAt), 64'(lat));
    checkOutput({tag, " doneCount"}, 64'(doneCount), 64'd1);
    checkOutput({tag, " busyCycles"}, 64'(busyCount), (lat > 1) ? 64'(lat) : 64'd0);
    checkOutput({tag, " hi"}, {32'd0, gotHi}, {32'd0, expv[63:32]});
    checkOutput({tag, " lo"}, {32'd0, gotLo}, {32'd0, expv[31:0]});
    lastHi = expv[63:32];
    lastLo = expv[31:0];
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int doneCount, doneAt;
    logic busyAt, busyAt11;
    logic [31:0] midHi, midLo, gotHi, gotLo;
    logic [1:0] ro;
    logic [31:0] rx, ry;

    rst = 1'b1; start = 1'b0; flush = 1'b0; op = 2'd0; a = 32'd0; b = 32'd0;
    repeat (3) @(posedge clk);
    #2;
    checkOutput("reset busy", {63'd0, busy}, 64'd0);
    checkOutput("reset done", {63'd0, done}, 64'd0);
    checkOutput("reset hi", {32'd0, hi}, 64'd0);
    checkOutput("reset lo", {32'd0, lo}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    applyStimulus("DIVU 100/7", 2'd3, 32'd100, 32'd7);
    applyStimulus("DIV -7/2", 2'd2, 32'hFFFFFFF9, 32'd2);
    applyStimulus("DIV min/-1", 2'd2, 32'h80000000, 32'hFFFFFFFF);
    applyStimulus("DIV 5/0", 2'd2, 32'd5, 32'd0);
    applyStimulus("DIVU x/0", 2'd3, 32'h89ABCDEF, 32'd0);
    applyStimulus("MULT -2*3", 2'd0, 32'hFFFFFFFE, 32'd3);
    applyStimulus("MULTU FFFFFFFE*3", 2'd1, 32'hFFFFFFFE, 32'd3);
    applyStimulus("MULT min*min", 2'd0, 32'h80000000, 32'h80000000);
    applyStimulus("DIVU max/1", 2'd3, 32'hFFFFFFFF, 32'd1);

    // Flush mid-divide at cycle 10, restart at cycle 11, completion expected at 44.
    doneCount = 0; doneAt = -1; busyAt = 1'b1; busyAt11 = 1'b0;
    midHi = 32'd0; midLo = 32'd0; gotHi = 32'd0; gotLo = 32'd0;
    for (int k = 0; k <= 50; k++) begin
      @(posedge clk); #1;
      if (k == 0 || k == 11) begin
        start = 1'b1; op = 2'd3; a = 32'd100; b = 32'd7;
      end else begin
        start = 1'b0; randomNoise();
      end
      flush = (k == 10);
      #1;
      if (k == 10) busyAt = busy;
      if (k == 11) busyAt11 = busy;
      if (k == 20) begin midHi = hi; midLo = lo; end
      if (done) begin doneCount++; doneAt = k; gotHi = hi; gotLo = lo; end
    end
    flush = 1'b0;
    checkOutput("flush busy@10", {63'd0, busyAt}, 64'd0);
    checkOutput("restart busy@11", {63'd0, busyAt11}, 64'd1);
    checkOutput("flush hi kept", {32'd0, midHi}, {32'd0, lastHi});
    checkOutput("flush lo kept", {32'd0, midLo}, {32'd0, lastLo});
    checkOutput("restart doneCount", 64'(doneCount), 64'd1);
    checkOutput("restart doneAt", 64'(doneAt), 64'd44);
    checkOutput("restart hi", {32'd0, gotHi}, 64'd2);
    checkOutput("restart lo", {32'd0, gotLo}, 64'd14);
    lastHi = 32'd2; lastLo = 32'd14;

    // Start and flush together: nothing may happen.
    doneCount = 0; busyAt = 1'b1;
    for (int k = 0; k <= 40; k++) begin
      @(posedge clk); #1;
      start = (k == 0); flush = (k == 0);
      if (k == 0) begin op = 2'd2; a = 32'd9; b = 32'd3; end
      else randomNoise();
      #1;
      if (k == 0) busyAt = busy;
      if (done) doneCount++;
    end
    flush = 1'b0;
    checkOutput("start+flush busy", {63'd0, busyAt}, 64'd0);
    checkOutput("start+flush done", 64'(doneCount), 64'd0);
    checkOutput("start+flush hi", {32'd0, hi}, {32'd0, lastHi});
    checkOutput("start+flush lo", {32'd0, lo}, {32'd0, lastLo});

    // Reset at cycle 5 of a divide clears HI/LO and suppresses done.
    doneCount = 0; busyAt = 1'b1; midHi = 32'hFFFFFFFF; midLo = 32'hFFFFFFFF;
    for (int k = 0; k <= 40; k++) begin
      @(posedge clk); #1;
      start = (k == 0);
      rst = (k == 5);
      if (k == 0) begin op = 2'd3; a = 32'd1000; b = 32'd3; end
      else randomNoise();
      #1;
      if (k == 5) busyAt = busy;
      if (k == 6) begin midHi = hi; midLo = lo; end
      if (done) doneCount++;
    end
    checkOutput("rst busy@5", {63'd0, busyAt}, 64'd0);
    checkOutput("rst hi cleared", {32'd0, midHi}, 64'd0);
    checkOutput("rst lo cleared", {32'd0, midLo}, 64'd0);
    checkOutput("rst no done", 64'(doneCount), 64'd0);
    lastHi = 32'd0; lastLo = 32'd0;

    for (int i = 0; i < 24; i++) begin
      ro = 2'($urandom_range(0, 3));
      rx = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
      case ($urandom_range(0, 7))
        0: ry = 32'd0;
        1: ry = 32'hFFFFFFFF;
        2: ry = 32'($urandom_range(1, 15));
        default: ry = $urandom;
      endcase
      applyStimulus($sformatf("rand%0d op%0d", i, ro), ro, rx, ry);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
